// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl_pkg / fp_issue_ctrl
//
// Sequential issue/writeback controller in front of the floating-point
// execute stage (fp_exe). It accepts one FP operation at a time over a
// valid/ready handshake. It issues the operation with a single-cycle enable
// pulse and waits for fp_exe to report ready. It then registers the
// writeback and keeps a sticky accumulation of the exception flags. A
// pipeline flush is forwarded to fp_exe as clear. An op that was flushed
// while still in flight is drained, so that its late ready cannot leak into
// the next operation.
//
// Ports
//   clock, reset          clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_data1..3          operands
//   req_op, req_fmt,      decoded op, format, resolved rounding mode
//   req_rm
//   req_rd, req_int_dst   destination index, destination is the integer file
//   fp_exe_i              enable/operands/op/fmt/rm to the execute stage
//   fp_exe_o              result/flags/ready from the execute stage
//   clear                 flush forwarded to the execute stage
//   flush                 pipeline kill of the in-flight op
//   wb_valid, wb_rd,      registered writeback (valid for one cycle)
//   wb_int, wb_data,
//   wb_flags
//   fflags_acc            sticky OR of written-back flags
//   fflags_clr            clears fflags_acc (CSR write)
//   busy                  controller is not idle
//   timeout_err           sticky WAIT timeout indication

package fp_issue_ctrl_pkg;

  typedef struct packed {
    logic fmadd;
    logic fmsub;
    logic fnmadd;
    logic fnmsub;
    logic fadd;
    logic fsub;
    logic fmul;
    logic fdiv;
    logic fsqrt;
    logic fsgnj;
    logic fcmp;
    logic fmax;
    logic fclass;
    logic fmv_i2f;
    logic fmv_f2i;
    logic fcvt_i2f;
    logic fcvt_f2i;
    logic fcvt_f2f;
  } fp_operation_type;

  typedef struct packed {
    logic [63:0]      data1;
    logic [63:0]      data2;
    logic [63:0]      data3;
    fp_operation_type op;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    logic             enable;
  } fp_exe_in_type;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
    logic        ready;
  } fp_exe_out_type;

endpackage

module fp_issue_ctrl
  import fp_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_data1,
  input  logic [63:0]      req_data2,
  input  logic [63:0]      req_data3,
  input  fp_operation_type req_op,
  input  logic [1:0]       req_fmt,
  input  logic [2:0]       req_rm,
  input  logic [4:0]       req_rd,
  input  logic             req_int_dst,
  output fp_exe_in_type    fp_exe_i,
  input  fp_exe_out_type   fp_exe_o,
  output logic             clear,
  input  logic             flush,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic             wb_int,
  output logic [63:0]      wb_data,
  output logic [4:0]       wb_flags,
  output logic [4:0]       fflags_acc,
  input  logic             fflags_clr,
  output logic             busy,
  output logic             timeout_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [63:0]      data1_r;
  logic [63:0]      data2_r;
  logic [63:0]      data3_r;
  fp_operation_type op_r;
  logic [1:0]       fmt_r;
  logic [2:0]       rm_r;
  logic [4:0]       rd_r;
  logic             int_dst_r;
  logic             mc_r;
  logic             timeout_err_r;

  logic             wb_valid_r;
  logic [4:0]       wb_rd_r;
  logic             wb_int_r;
  logic [63:0]      wb_data_r;
  logic [4:0]       wb_flags_r;
  logic [4:0]       fflags_acc_r;

  logic             capture_s;
  fp_exe_in_type    exe_in_s;

  // Ops whose ready may arrive after the issue cycle.
  function automatic logic is_multicycle(input fp_operation_type op);
    return op.fmadd | op.fmsub | op.fnmadd | op.fnmsub | op.fadd |
           op.fsub | op.fmul | op.fdiv | op.fsqrt;
  endfunction

  // A result is taken only from a live (not flushed) ISSUE or WAIT cycle.
  always_comb begin
    capture_s = 1'b0;
    if ((state_r == ISSUE || state_r == WAIT) && !flush) begin
      capture_s = fp_exe_o.ready;
    end else begin
      capture_s = 1'b0;
    end
  end

  // Execute-stage request is decoded from state: held fields only in ISSUE.
  always_comb begin
    exe_in_s = '0;
    if (state_r == ISSUE) begin
      exe_in_s.enable = 1'b1;
      exe_in_s.data1  = data1_r;
      exe_in_s.data2  = data2_r;
      exe_in_s.data3  = data3_r;
      exe_in_s.op     = op_r;
      exe_in_s.fmt    = fmt_r;
      exe_in_s.rm     = rm_r;
    end else begin
      exe_in_s = '0;
    end
  end

  // Control FSM, request holding registers, timeout counter, sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      data1_r       <= 64'd0;
      data2_r       <= 64'd0;
      data3_r       <= 64'd0;
      op_r          <= '0;
      fmt_r         <= 2'd0;
      rm_r          <= 3'd0;
      rd_r          <= 5'd0;
      int_dst_r     <= 1'b0;
      mc_r          <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            data1_r   <= req_data1;
            data2_r   <= req_data2;
            data3_r   <= req_data3;
            op_r      <= req_op;
            fmt_r     <= req_fmt;
            rm_r      <= req_rm;
            rd_r      <= req_rd;
            int_dst_r <= req_int_dst;
            mc_r      <= is_multicycle(req_op);
            state_r   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_r <= '0;
          if (flush) begin
            state_r <= mc_r ? DRAIN : IDLE;
          end else if (fp_exe_o.ready) begin
            state_r <= IDLE;
          end else begin
            // A simple op should never get here; WAIT still bounds it.
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            cnt_r   <= '0;
            state_r <= mc_r ? DRAIN : IDLE;
          end else if (fp_exe_o.ready) begin
            state_r <= IDLE;
          end else if (cnt_r == CNT_LAST) begin
            timeout_err_r <= 1'b1;
            state_r       <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DRAIN: begin
          // The ready of the killed op (or the timeout) ends the drain.
          if (fp_exe_o.ready || cnt_r == CNT_LAST) begin
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Writeback registers and sticky flag accumulation.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid_r   <= 1'b0;
      wb_rd_r      <= 5'd0;
      wb_int_r     <= 1'b0;
      wb_data_r    <= 64'd0;
      wb_flags_r   <= 5'd0;
      fflags_acc_r <= 5'd0;
    end else begin
      wb_valid_r <= capture_s;
      if (capture_s) begin
        wb_rd_r    <= rd_r;
        wb_int_r   <= int_dst_r;
        wb_data_r  <= fp_exe_o.result;
        wb_flags_r <= fp_exe_o.flags;
      end
      // Flags written back in the clear cycle survive the clear.
      fflags_acc_r <= (fflags_clr ? 5'd0 : fflags_acc_r) |
                      (wb_valid_r ? wb_flags_r : 5'd0);
    end
  end

  assign req_ready   = (state_r == IDLE);
  assign busy        = (state_r != IDLE);
  assign clear       = flush;
  assign fp_exe_i    = exe_in_s;
  assign wb_valid    = wb_valid_r;
  assign wb_rd       = wb_rd_r;
  assign wb_int      = wb_int_r;
  assign wb_data     = wb_data_r;
  assign wb_flags    = wb_flags_r;
  assign fflags_acc  = fflags_acc_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// tb_fp_issue_ctrl
//
// Self-checking bench for fp_issue_ctrl. A stub execute stage answers each
// enable with ready after a chosen latency. The stub's result is a function
// of the operands it actually received. Per operation, the reference model
// derives from the operation-level rules the cycle of the enable, of the
// writeback and of the return to idle, and whether a timeout occurs. Every
// cycle is then compared against that timeline, together with a scoreboard
// of the writeback registers and the sticky flags.

module tb_fp_issue_ctrl;
  import fp_issue_ctrl_pkg::*;

  localparam int TMO = 64;
  localparam int E   = 1;   // enable cycle relative to the accept cycle

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [63:0]      req_data1, req_data2, req_data3;
  fp_operation_type req_op;
  logic [1:0]       req_fmt;
  logic [2:0]       req_rm;
  logic [4:0]       req_rd;
  logic             req_int_dst;
  fp_exe_in_type    fp_exe_i;
  fp_exe_out_type   fp_exe_o;
  logic             clear, flush;
  logic             wb_valid, wb_int;
  logic [4:0]       wb_rd, wb_flags, fflags_acc;
  logic [63:0]      wb_data;
  logic             fflags_clr, busy, timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard of architecturally visible registers.
  logic [63:0] wb_data_m  = 64'd0;
  logic [4:0]  wb_rd_m    = 5'd0;
  logic        wb_int_m   = 1'b0;
  logic [4:0]  wb_flags_m = 5'd0;
  logic [4:0]  acc_m      = 5'd0;
  logic        terr_m     = 1'b0;

  fp_issue_ctrl #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
    .req_op(req_op), .req_fmt(req_fmt), .req_rm(req_rm),
    .req_rd(req_rd), .req_int_dst(req_int_dst),
    .fp_exe_i(fp_exe_i), .fp_exe_o(fp_exe_o),
    .clear(clear), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_int(wb_int),
    .wb_data(wb_data), .wb_flags(wb_flags),
    .fflags_acc(fflags_acc), .fflags_clr(fflags_clr),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic fp_operation_type mk_op(input int idx);
    logic [17:0] v;
    v = 18'd0;
    v[17 - idx] = 1'b1;
    return fp_operation_type'(v);
  endfunction

  function automatic bit is_nan64(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  // Behaviour of the stub execute stage.
  function automatic logic [63:0] stub_fn(input fp_operation_type op, input logic [63:0] a,
                                          input logic [63:0] b, input logic [63:0] c,
                                          input logic [1:0] fmt, input logic [2:0] rm);
    if (op.fsgnj) return {b[63], a[62:0]};
    else if (op.fcmp) return (is_nan64(a) || is_nan64(b)) ? 64'd0 : {63'd0, a == b};
    else return a ^ {b[31:0], b[63:32]} ^ ~c ^ {59'd0, fmt, rm};
  endfunction

  // One operation: lat = ready delay after enable (>TMO means never),
  // fl = flush offset after enable (-1 none), clr_at = cycle of fflags_clr.
  task automatic run_op(input fp_operation_type op, input logic [63:0] d1, input logic [63:0] d2,
                        input logic [63:0] d3, input logic [1:0] fmt, input logic [2:0] rm,
                        input logic [4:0] rd, input int lat, input int fl, input int clr_at,
                        input logic [4:0] flg);
    bit mc, idst, flushed, tmo;
    int idle_at, wb_at;
    logic [63:0] res_m, stub_res;
    mc   = op.fmadd | op.fmsub | op.fnmadd | op.fnmsub | op.fadd | op.fsub |
           op.fmul | op.fdiv | op.fsqrt;
    idst = op.fcmp | op.fclass | op.fmv_f2i | op.fcvt_f2i;
    res_m    = stub_fn(op, d1, d2, d3, fmt, rm);
    stub_res = 64'hDEAD_BEEF_DEAD_BEEF;
    wb_at = -1;
    tmo   = 1'b0;
    flushed = (fl == 0) || (mc && fl >= 1 && fl <= lat && fl <= TMO);
    if (flushed) begin
      if (!mc) idle_at = E + 1;
      else if (lat > fl && lat <= TMO) idle_at = E + lat + 1;
      else idle_at = E + fl + 1 + TMO;
    end else if (lat <= TMO) begin
      wb_at   = E + lat + 1;
      idle_at = wb_at;
    end else begin
      tmo     = 1'b1;
      idle_at = E + TMO + 1;
    end
    for (int c = 0; c <= idle_at; c++) begin
      if (c == E && fp_exe_i.enable)
        stub_res = stub_fn(fp_exe_i.op, fp_exe_i.data1, fp_exe_i.data2, fp_exe_i.data3,
                           fp_exe_i.fmt, fp_exe_i.rm);
      if (c == wb_at) begin
        wb_data_m = res_m; wb_rd_m = rd; wb_int_m = idst; wb_flags_m = flg;
      end
      req_valid   = (c == 0);
      req_op      = op;  req_data1 = d1; req_data2 = d2; req_data3 = d3;
      req_fmt     = fmt; req_rm = rm; req_rd = rd; req_int_dst = idst;
      flush       = (fl >= 0) && (c == E + fl);
      fflags_clr  = (c == clr_at);
      fp_exe_o.ready  = (lat <= TMO) && (c == E + lat);
      fp_exe_o.result = fp_exe_o.ready ? stub_res : {$urandom, $urandom};
      fp_exe_o.flags  = fp_exe_o.ready ? flg : 5'($urandom);
      #1;
      check_val("req_ready", req_ready, !(c >= E && c < idle_at));
      check_val("busy", busy, (c >= E && c < idle_at));
      check_val("clear", clear, flush);
      check_val("enable", fp_exe_i.enable, c == E);
      if (c == E) begin
        check_val("exe_d1", fp_exe_i.data1, d1);
        check_val("exe_d2", fp_exe_i.data2, d2);
        check_val("exe_d3", fp_exe_i.data3, d3);
        check_val("exe_ctl", {fp_exe_i.op, fp_exe_i.fmt, fp_exe_i.rm}, {op, fmt, rm});
      end else begin
        check_val("exe_zero", fp_exe_i != '0, 1'b0);
      end
      check_val("wb_valid", wb_valid, c == wb_at);
      check_val("wb_data", wb_data, wb_data_m);
      check_val("wb_tag", {wb_rd, wb_int, wb_flags}, {wb_rd_m, wb_int_m, wb_flags_m});
      check_val("fflags_acc", fflags_acc, acc_m);
      check_val("timeout_err", timeout_err, terr_m);
      acc_m = (fflags_clr ? 5'd0 : acc_m) | ((c == wb_at) ? wb_flags_m : 5'd0);
      if (tmo && c + 1 == idle_at) terr_m = 1'b1;
      @(posedge clock); #1;
    end
    req_valid = 1'b0; flush = 1'b0; fflags_clr = 1'b0; fp_exe_o = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, {req_ready, busy, clear}, 3'b100);
    check_val({tag, "_wb"}, {wb_valid, wb_rd, wb_int, wb_flags}, 12'd0);
    check_val({tag, "_wbdata"}, wb_data, 64'd0);
    check_val({tag, "_flags"}, {fflags_acc, timeout_err}, 6'd0);
    check_val({tag, "_exe"}, fp_exe_i != '0, 1'b0);
  endtask

  initial begin
    int idx, lat, fl, clr;
    fp_operation_type op;
    reset = 1'b1; req_valid = 1'b0; flush = 1'b0; fflags_clr = 1'b0;
    req_data1 = 64'd0; req_data2 = 64'd0; req_data3 = 64'd0; req_op = '0;
    req_fmt = 2'd0; req_rm = 3'd0; req_rd = 5'd0; req_int_dst = 1'b0; fp_exe_o = '0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // fsgnj: sign of data2 onto data1 -> 0xBFF0...
    op = mk_op(9);
    run_op(op, 64'h3FF0_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 2'd1, 3'd0,
           5'd3, 0, -1, -1, 5'h00);
    // fdiv with ready 10 cycles after enable, NX
    op = mk_op(7);
    run_op(op, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 64'd0, 2'd1, 3'd0,
           5'd4, 10, -1, -1, 5'h01);
    // fcmp with sNaN, clear of sticky flags in the writeback cycle
    op = mk_op(10);
    run_op(op, 64'h7FF4_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'd0, 2'd1, 3'd2,
           5'd10, 0, -1, E + 1, 5'h10);
    // fmul flushed 3 cycles into WAIT, stray ready 2 cycles later
    op = mk_op(6);
    run_op(op, 64'h1, 64'h2, 64'h3, 2'd1, 3'd0, 5'd5, 6, 4, -1, 5'h02);
    // next request accepted after the drain
    op = mk_op(4);
    run_op(op, 64'h11, 64'h22, 64'h33, 2'd0, 3'd1, 5'd6, 3, -1, -1, 5'h04);
    // fsqrt that never completes -> timeout
    op = mk_op(8);
    run_op(op, 64'h5, 64'h6, 64'h7, 2'd1, 3'd0, 5'd7, TMO + 100, -1, -1, 5'h08);
    // ready exactly on the last WAIT cycle still wins over the timeout
    op = mk_op(0);
    run_op(op, 64'h9, 64'hA, 64'hB, 2'd1, 3'd0, 5'd8, TMO, -1, -1, 5'h04);

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      idx = $urandom_range(0, 17);
      op  = mk_op(idx);
      if (idx <= 8) begin
        case ($urandom_range(0, 9))
          0:       lat = TMO + 3;
          1:       lat = TMO;
          default: lat = $urandom_range(0, 12);
        endcase
      end else begin
        lat = 0;
      end
      fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ((lat > TMO) ? TMO : lat) + 1) : -1;
      clr = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 14) : -1;
      run_op(op, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             2'($urandom), 3'($urandom), 5'($urandom), lat, fl, clr, 5'($urandom));
    end

    // Reset while waiting on an fdiv, then a late ready: abandoned silently.
    req_op = mk_op(7); req_data1 = 64'h1234; req_rd = 5'd9; req_int_dst = 1'b0;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fp_exe_o.ready  = (k == 0);
      fp_exe_o.result = 64'hFFFF_0000_FFFF_0000;
      fp_exe_o.flags  = 5'h1F;
      #1;
      check_reset_outputs("after_reset");
      @(posedge clock); #1;
    end
    fp_exe_o = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
